// File: rtl/sparse_pkg.sv
// Shared types for the sparse intersection engine and its downstream MAC consumer:
// default element widths, the matched-pair record and the merge FSM state encoding.
package sparse_pkg;

    // Default element widths; the pair record is sized from these.
    localparam int DEF_IDX_W  = 8;
    localparam int DEF_DATA_W = 16;

    // One matched pair: the A value, the B value and a flag saying the record is live.
    typedef struct packed {
        logic [DEF_DATA_W-1:0] a;
        logic [DEF_DATA_W-1:0] b;
        logic                  valid;
    } pair;

    // Merge controller states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MERGE   = 3'd1,
        DRAIN_A = 3'd2,
        DRAIN_B = 3'd3,
        FLUSH   = 3'd4
    } state_t;

endpackage

// File: rtl/pair_fifo.sv
// Small first-word-fall-through FIFO of matched pairs. Each entry carries its own
// valid flag so the head can be presented straight from the storage the cycle after
// a push, and so an asynchronous reset invalidates every buffered pair at once.
module pair_fifo
    import sparse_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  pair  push_data,
    input  logic pop,
    output pair  head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W:0]        count_reg;

    logic                  push_en;
    logic                  pop_en;

    logic [DEF_DATA_W-1:0] entry_a     [N];
    logic [DEF_DATA_W-1:0] entry_b     [N];
    logic                  entry_valid [N];

    assign full    = (count_reg == (PTR_W+1)'(N));
    assign empty   = (count_reg == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_entry
            logic [DEF_DATA_W-1:0] a_reg;
            logic [DEF_DATA_W-1:0] b_reg;
            logic                  valid_reg;
            logic                  wr_hit;
            logic                  rd_hit;

            assign wr_hit = push_en && (wr_ptr_reg == PTR_W'(gi));
            assign rd_hit = pop_en  && (rd_ptr_reg == PTR_W'(gi));

            // Payload storage: written on push, never cleared (the valid flag guards it).
            always_ff @(posedge clk) begin
                if (wr_hit) begin
                    a_reg <= push_data.a;
                    b_reg <= push_data.b;
                end
            end

            // Occupancy flag: set on push, cleared on pop, dropped immediately by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                end else if (wr_hit) begin
                    valid_reg <= 1'b1;
                end else if (rd_hit) begin
                    valid_reg <= 1'b0;
                end
            end

            assign entry_a[gi]     = a_reg;
            assign entry_b[gi]     = b_reg;
            assign entry_valid[gi] = valid_reg;
        end
    endgenerate

    // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_en && !pop_en) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_en && !push_en) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Head presentation: a zeroed record whenever the head slot holds nothing.
    always_comb begin
        head = '0;
        if (entry_valid[rd_ptr_reg]) begin
            head.a     = entry_a[rd_ptr_reg];
            head.b     = entry_b[rd_ptr_reg];
            head.valid = 1'b1;
        end
    end

endmodule

// File: rtl/sparse_intersect.sv
// Sparse-vector intersection: merges two index-ascending element streams, emits a
// {a, b} value pair for every index present in both, and signals job completion once
// both streams have ended and every buffered pair has been consumed.
module sparse_intersect
    import sparse_pkg::*;
#(
    parameter int N      = 4,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [IDX_W-1:0]  a_idx_i,
    input  logic [DATA_W-1:0] a_val_i,
    input  logic              a_last_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [IDX_W-1:0]  b_idx_i,
    input  logic [DATA_W-1:0] b_val_i,
    input  logic              b_last_i,
    output pair               pair_o,
    output logic              pair_valid_o,
    input  logic              pair_ready_i,
    output logic [IDX_W:0]    match_cnt_o,
    output logic              done_o
);

    localparam logic [IDX_W:0] CNT_MAX = '1;

    state_t         state_reg;
    logic [IDX_W:0] match_cnt_reg;
    logic           done_reg;

    logic           a_ready;
    logic           b_ready;
    logic           a_fire;
    logic           b_fire;
    logic           push;
    pair            push_data;
    pair            head;
    logic           fifo_full;
    logic           fifo_empty;

    // Stream readies: compare heads in MERGE, swallow the leftover stream while draining.
    // pair_ready_i deliberately plays no part here; only FIFO fullness can stall a match.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state_reg)
            MERGE: begin
                if (a_valid_i && b_valid_i) begin
                    if (a_idx_i < b_idx_i) begin
                        a_ready = 1'b1;
                    end else if (a_idx_i > b_idx_i) begin
                        b_ready = 1'b1;
                    end else if (!fifo_full) begin
                        a_ready = 1'b1;
                        b_ready = 1'b1;
                    end
                end
            end
            DRAIN_A: a_ready = a_valid_i;
            DRAIN_B: b_ready = b_valid_i;
            default: ;
        endcase
    end

    assign a_fire = a_valid_i && a_ready;
    assign b_fire = b_valid_i && b_ready;

    // Both streams only move together in MERGE when their indices match.
    assign push = (state_reg == MERGE) && a_fire && b_fire;

    // Build the record to enqueue for a match.
    always_comb begin
        push_data       = '0;
        push_data.a     = DEF_DATA_W'(a_val_i);
        push_data.b     = DEF_DATA_W'(b_val_i);
        push_data.valid = 1'b1;
    end

    pair_fifo #(
        .N (N)
    ) u_pair_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pair_ready_i),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Job sequencing, saturating match counter and the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            match_cnt_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (a_valid_i || b_valid_i) begin
                        state_reg     <= MERGE;
                        match_cnt_reg <= '0;
                    end
                end
                MERGE: begin
                    if (push && (match_cnt_reg != CNT_MAX)) begin
                        match_cnt_reg <= match_cnt_reg + 1'b1;
                    end
                    // A stream that has ended leaves the other one to be drained; if both
                    // end together only the FIFO remains to empty.
                    if (a_fire && a_last_i && b_fire && b_last_i) begin
                        state_reg <= FLUSH;
                    end else if (a_fire && a_last_i) begin
                        state_reg <= DRAIN_B;
                    end else if (b_fire && b_last_i) begin
                        state_reg <= DRAIN_A;
                    end
                end
                DRAIN_A: begin
                    if (a_fire && a_last_i) begin
                        state_reg <= FLUSH;
                    end
                end
                DRAIN_B: begin
                    if (b_fire && b_last_i) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fifo_empty) begin
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign a_ready_o    = a_ready;
    assign b_ready_o    = b_ready;
    assign pair_o       = head;
    assign pair_valid_o = head.valid;
    assign match_cnt_o  = match_cnt_reg;
    assign done_o       = done_reg;

endmodule

// File: tb/tb_sparse_intersect.sv
// Self-checking bench for sparse_intersect: directed scenarios plus randomized jobs,
// judged against a stream-level reference of the merge rules and a set-intersection count.
module tb_sparse_intersect;
    import sparse_pkg::*;

    localparam int N      = 4;
    localparam int IDX_W  = 8;
    localparam int DATA_W = 16;
    localparam int MAXE   = 64;
    localparam int CNT_SAT = (1 << (IDX_W + 1)) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid_i;
    logic              a_ready_o;
    logic [IDX_W-1:0]  a_idx_i;
    logic [DATA_W-1:0] a_val_i;
    logic              a_last_i;
    logic              b_valid_i;
    logic              b_ready_o;
    logic [IDX_W-1:0]  b_idx_i;
    logic [DATA_W-1:0] b_val_i;
    logic              b_last_i;
    pair               pair_o;
    logic              pair_valid_o;
    logic              pair_ready_i;
    logic [IDX_W:0]    match_cnt_o;
    logic              done_o;

    always #5 clk = ~clk;

    sparse_intersect #(
        .N      (N),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid_i    (a_valid_i),
        .a_ready_o    (a_ready_o),
        .a_idx_i      (a_idx_i),
        .a_val_i      (a_val_i),
        .a_last_i     (a_last_i),
        .b_valid_i    (b_valid_i),
        .b_ready_o    (b_ready_o),
        .b_idx_i      (b_idx_i),
        .b_val_i      (b_val_i),
        .b_last_i     (b_last_i),
        .pair_o       (pair_o),
        .pair_valid_o (pair_valid_o),
        .pair_ready_i (pair_ready_i),
        .match_cnt_o  (match_cnt_o),
        .done_o       (done_o)
    );

    int checks = 0;
    int errors = 0;

    int a_idx_arr [MAXE];
    int a_val_arr [MAXE];
    int a_len;
    int b_idx_arr [MAXE];
    int b_val_arr [MAXE];
    int b_len;

    int exp_a_q [$];
    int exp_b_q [$];
    int got_a_q [$];
    int got_b_q [$];
    int accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic gen_random_streams();
        int idx;
        a_len = $urandom_range(1, 12);
        b_len = $urandom_range(1, 12);
        idx = $urandom_range(0, 4);
        for (int i = 0; i < a_len; i++) begin
            a_idx_arr[i] = idx;
            a_val_arr[i] = $urandom_range(0, 65535);
            idx += $urandom_range(1, 2);
        end
        idx = $urandom_range(0, 4);
        for (int i = 0; i < b_len; i++) begin
            b_idx_arr[i] = idx;
            b_val_arr[i] = $urandom_range(0, 65535);
            idx += $urandom_range(1, 2);
        end
    endtask

    task automatic idle_inputs();
        a_valid_i    = 1'b0;
        b_valid_i    = 1'b0;
        a_last_i     = 1'b0;
        b_last_i     = 1'b0;
        pair_ready_i = 1'b0;
    endtask

    // Runs one job. pair_ready_i follows pr_mask for the first pr_len cycles, then is random.
    // fill_exp >= 0 checks the number of accepted matches once the mask window ends.
    task automatic run_job(input string name, input bit dense, input logic [31:0] pr_mask,
                           input int pr_len, input int fill_exp, input int max_cycles,
                           input bit abort_after);
        int  ai = 0;
        int  bi = 0;
        bit  a_done = 0;
        bit  b_done = 0;
        bit  started = 0;
        bit  finished = 0;
        int  done_cnt = 0;
        int  cyc = 0;
        int  common = 0;
        bit  exp_ar;
        bit  exp_br;
        bit  a_fire;
        bit  b_fire;

        exp_a_q.delete();
        exp_b_q.delete();
        got_a_q.delete();
        got_b_q.delete();
        accepted = 0;
        for (int i = 0; i < a_len; i++)
            for (int j = 0; j < b_len; j++)
                if (a_idx_arr[i] == b_idx_arr[j]) common++;

        while (!finished) begin
            @(negedge clk);
            a_valid_i = !a_done && (dense || ($urandom_range(0, 3) != 0));
            b_valid_i = !b_done && (dense || ($urandom_range(0, 3) != 0));
            if (!a_done) begin
                a_idx_i  = IDX_W'(a_idx_arr[ai]);
                a_val_i  = DATA_W'(a_val_arr[ai]);
                a_last_i = (ai == a_len - 1);
            end
            if (!b_done) begin
                b_idx_i  = IDX_W'(b_idx_arr[bi]);
                b_val_i  = DATA_W'(b_val_arr[bi]);
                b_last_i = (bi == b_len - 1);
            end
            pair_ready_i = (cyc < pr_len) ? pr_mask[cyc] : ($urandom_range(0, 3) != 0);
            #1;

            if (fill_exp >= 0 && cyc == pr_len) chk({name, "_fill"}, accepted, fill_exp);

            // Reference readies from the stream-level merge rules.
            exp_ar = 0;
            exp_br = 0;
            if (started && !(a_done && b_done)) begin
                if (a_done) exp_br = b_valid_i;
                else if (b_done) exp_ar = a_valid_i;
                else if (a_valid_i && b_valid_i) begin
                    if (a_idx_arr[ai] < b_idx_arr[bi]) exp_ar = 1;
                    else if (a_idx_arr[ai] > b_idx_arr[bi]) exp_br = 1;
                    else if (exp_a_q.size() < N) begin
                        exp_ar = 1;
                        exp_br = 1;
                    end
                end
            end
            chk({name, "_a_ready"}, a_ready_o, exp_ar);
            chk({name, "_b_ready"}, b_ready_o, exp_br);
            chk({name, "_pair_valid"}, pair_valid_o, exp_a_q.size() != 0);
            if (!pair_valid_o) chk({name, "_empty_head"}, {pair_o.a, pair_o.b}, 0);
            if (started) chk({name, "_match_cnt"}, match_cnt_o, accepted);
            if (done_o) begin
                done_cnt++;
                chk({name, "_done_early"}, (a_done && b_done && exp_a_q.size() == 0), 1);
            end

            a_fire = a_valid_i && a_ready_o;
            b_fire = b_valid_i && b_ready_o;
            if (pair_valid_o && pair_ready_i && exp_a_q.size() != 0) begin
                chk({name, "_pair_a"}, pair_o.a, exp_a_q[0]);
                chk({name, "_pair_b"}, pair_o.b, exp_b_q[0]);
                $display("%s pair a=%0d b=%0d", name, pair_o.a, pair_o.b);
                got_a_q.push_back(int'(pair_o.a));
                got_b_q.push_back(int'(pair_o.b));
                void'(exp_a_q.pop_front());
                void'(exp_b_q.pop_front());
            end
            if (a_fire && b_fire && !a_done && !b_done && a_idx_arr[ai] == b_idx_arr[bi]) begin
                exp_a_q.push_back(a_val_arr[ai]);
                exp_b_q.push_back(b_val_arr[bi]);
                accepted++;
            end
            if (a_fire) begin
                if (ai == a_len - 1) a_done = 1;
                ai++;
            end
            if (b_fire) begin
                if (bi == b_len - 1) b_done = 1;
                bi++;
            end
            if (!started && (a_valid_i || b_valid_i)) started = 1;
            cyc++;

            if (abort_after && cyc >= max_cycles) finished = 1;
            else if (done_cnt > 0) finished = 1;
            else if (cyc >= max_cycles) begin
                chk({name, "_timeout"}, 0, 1);
                finished = 1;
            end
        end

        if (!abort_after) begin
            idle_inputs();
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                #1;
                if (done_o) done_cnt++;
            end
            chk({name, "_done_pulses"}, done_cnt, 1);
            chk({name, "_final_cnt"}, match_cnt_o, (common > CNT_SAT) ? CNT_SAT : common);
            chk({name, "_accepted"}, accepted, common);
            chk({name, "_pairs_left"}, exp_a_q.size(), 0);
            chk({name, "_final_valid"}, pair_valid_o, 0);
            $display("%s job a_len=%0d b_len=%0d matches=%0d cycles=%0d", name, a_len, b_len, common, cyc);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_idx_i = '0;
        a_val_i = '0;
        b_idx_i = '0;
        b_val_i = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        #1;
        chk("rst_a_ready", a_ready_o, 0);
        chk("rst_b_ready", b_ready_o, 0);
        chk("rst_pair_valid", pair_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_match_cnt", match_cnt_o, 0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Overlapping streams: matches at indices 3 and 5.
        a_len = 3; b_len = 3;
        a_idx_arr[0] = 1; a_idx_arr[1] = 3; a_idx_arr[2] = 5;
        a_val_arr[0] = 10; a_val_arr[1] = 30; a_val_arr[2] = 50;
        b_idx_arr[0] = 3; b_idx_arr[1] = 4; b_idx_arr[2] = 5;
        b_val_arr[0] = 7; b_val_arr[1] = 8; b_val_arr[2] = 9;
        run_job("overlap", 1, 32'h0, 0, -1, 200, 0);
        chk("overlap_npairs", got_a_q.size(), 2);
        if (got_a_q.size() == 2) begin
            chk("overlap_p0_a", got_a_q[0], 30);
            chk("overlap_p0_b", got_b_q[0], 7);
            chk("overlap_p1_a", got_a_q[1], 50);
            chk("overlap_p1_b", got_b_q[1], 9);
        end
        repeat (2) @(negedge clk);

        // Disjoint streams: no pairs at all.
        a_len = 2; b_len = 2;
        a_idx_arr[0] = 0; a_idx_arr[1] = 2;
        b_idx_arr[0] = 1; b_idx_arr[1] = 3;
        for (int i = 0; i < 2; i++) begin
            a_val_arr[i] = 100 + i;
            b_val_arr[i] = 200 + i;
        end
        run_job("disjoint", 1, 32'h0, 0, -1, 200, 0);
        chk("disjoint_npairs", got_a_q.size(), 0);
        repeat (2) @(negedge clk);

        // Six equal indices with the consumer stalled: FIFO fills to N, then drains in order.
        a_len = 6; b_len = 6;
        for (int i = 0; i < 6; i++) begin
            a_idx_arr[i] = i; a_val_arr[i] = 3 * i + 1;
            b_idx_arr[i] = i; b_val_arr[i] = 5 * i + 2;
        end
        run_job("fill", 1, 32'h0, 16, N, 300, 0);
        chk("fill_npairs", got_a_q.size(), 6);
        repeat (2) @(negedge clk);

        // A ends first, B's tail is drained and discarded.
        a_len = 1; b_len = 3;
        a_idx_arr[0] = 5; a_val_arr[0] = 55;
        b_idx_arr[0] = 1; b_idx_arr[1] = 2; b_idx_arr[2] = 9;
        b_val_arr[0] = 11; b_val_arr[1] = 22; b_val_arr[2] = 99;
        run_job("drain_b", 1, 32'h0, 0, -1, 200, 0);
        chk("drain_b_npairs", got_a_q.size(), 0);
        repeat (2) @(negedge clk);

        // Simultaneous push and pop with two pairs buffered (cycle 3), then stall again:
        // occupancy must be 2 after that cycle, so exactly 5 matches fit before the stall.
        a_len = 6; b_len = 6;
        for (int i = 0; i < 6; i++) begin
            a_idx_arr[i] = 2 * i; a_val_arr[i] = 1000 + i;
            b_idx_arr[i] = 2 * i; b_val_arr[i] = 2000 + i;
        end
        run_job("pushpop", 1, 32'h0000_0008, 12, 5, 300, 0);
        chk("pushpop_npairs", got_a_q.size(), 6);
        repeat (2) @(negedge clk);

        // Randomized jobs against the reference.
        for (int j = 0; j < 10; j++) begin
            gen_random_streams();
            run_job($sformatf("rand%0d", j), 0, 32'h0, 0, -1, 400, 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Reset in the middle of a job with three pairs buffered.
        a_len = 5; b_len = 5;
        for (int i = 0; i < 5; i++) begin
            a_idx_arr[i] = i + 1; a_val_arr[i] = 40 + i;
            b_idx_arr[i] = i + 1; b_val_arr[i] = 60 + i;
        end
        run_job("midrst", 1, 32'h0, 16, -1, 4, 1);
        @(posedge clk);
        #2;
        chk("midrst_buffered", pair_valid_o, 1);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("midrst_pair_valid", pair_valid_o, 0);
        chk("midrst_a_ready", a_ready_o, 0);
        chk("midrst_b_ready", b_ready_o, 0);
        chk("midrst_match_cnt", match_cnt_o, 0);
        chk("midrst_done", done_o, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("postrst_done", done_o, 0);
            chk("postrst_pair_valid", pair_valid_o, 0);
            chk("postrst_a_ready", a_ready_o, 0);
        end

        // Recovery job after the reset.
        gen_random_streams();
        run_job("recover", 0, 32'h0, 0, -1, 400, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
